// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port A arbiter: access sizes, requester count and
// the response-stage record. Used by ram_arb_grant and ram_port_arbiter.
package ram_arb_pkg;

   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD} access_size_t;

   localparam int NUM_REQ   = 2;
   // Offset field is sized for RAM words of up to 64 bytes.
   localparam int OFF_MAX_W = 6;

   typedef struct packed {
      logic                 valid;
      logic                 owner;
      logic [OFF_MAX_W-1:0] offset;
      access_size_t         size;
      logic                 write;
      logic                 err;
   } rsp_q_t;

endpackage

// File: rtl/ram_arb_grant.sv
// Two-requester grant logic: fixed priority to requester 0, or alternating
// priority when ARB_ROUND_ROBIN_EN is defined.
module ram_arb_grant
   import ram_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
   input  logic               clk,
   input  logic               rst_n,
`endif
   input  logic [NUM_REQ-1:0] valid,
   output logic [NUM_REQ-1:0] grant
);

`ifdef ARB_ROUND_ROBIN_EN
   // Holds the requester favoured on the next contested cycle, i.e. the one
   // not granted last; reset value 0 lets requester 0 win the first contest.
   logic ptr_q;

   // NOTE: combinational outputs get a default first so no latch is inferred.
   always_comb begin
      grant = '0;
      if (&valid) grant[ptr_q] = 1'b1;
      else        grant = valid;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ptr_q <= 1'b0;
      else if (|grant) ptr_q <= grant[0];
   end
`else
   always_comb begin
      grant    = '0;
      grant[0] = valid[0];
      grant[1] = valid[1] & ~valid[0];
   end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares block-RAM port A between the load/store unit and the debug master:
// byte-lane mapping, legality checks and a one-stage response pipeline.
// Optional macro ARB_ROUND_ROBIN_EN selects alternating arbitration.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int          BYTES    = 4,
   parameter int          WIDTH    = BYTES * 8,
   parameter logic [31:0] MAX_ADDR = 32'h1000
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ-1:0]              req_write,
   input  logic [NUM_REQ-1:0][1:0]         req_size,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]              rsp_valid,
   output logic [WIDTH-1:0]                rsp_rdata,
   output logic                            rsp_err,
   output logic [WIDTH-1:0]                ram_addr,
   output logic [BYTES-1:0]                ram_we,
   output logic [WIDTH-1:0]                ram_wdata,
   input  logic [WIDTH-1:0]                ram_rdata
);

   localparam int OFF_W = $clog2(BYTES);

   logic [NUM_REQ-1:0] grant;
   logic               any_grant;
   logic               sel;
   logic [WIDTH-1:0]   addr;
   logic [WIDTH-1:0]   wdata;
   logic               write;
   access_size_t       size;
   logic [OFF_W-1:0]   offset;
   logic [WIDTH-1:0]   word_addr;
   logic [OFF_W:0]     span;
   logic [BYTES-1:0]   lane_mask;
   logic               align_ok;
   logic               fit_ok;
   logic               range_ok;
   logic               legal;
   logic [WIDTH-1:0]   addr_hold_q;
   rsp_q_t             rsp_d;
   rsp_q_t             rsp_q;
   logic [WIDTH-1:0]   rd_shift;

   // Holding the arbiter's inputs low keeps req_ready at 0 throughout reset.
   ram_arb_grant u_grant (
`ifdef ARB_ROUND_ROBIN_EN
      .clk   (clk),
      .rst_n (rst_n),
`endif
      .valid (req_valid & {NUM_REQ{rst_n}}),
      .grant (grant)
   );

   assign req_ready = grant;
   assign any_grant = |grant;
   assign sel       = grant[1];

   assign addr      = req_addr[sel];
   assign wdata     = req_wdata[sel];
   assign write     = req_write[sel];
   assign size      = access_size_t'(req_size[sel]);
   assign offset    = addr[OFF_W-1:0];
   assign word_addr = addr >> OFF_W;

   always_comb begin
      span      = '0;
      lane_mask = '0;
      align_ok  = 1'b0;
      unique case (size)
         SZ_BYTE: begin
            span      = (OFF_W+1)'(1);
            lane_mask = BYTES'(4'b0001);
            align_ok  = 1'b1;
         end
         SZ_HALF: begin
            span      = (OFF_W+1)'(2);
            lane_mask = BYTES'(4'b0011);
            align_ok  = ~offset[0];
         end
         SZ_WORD: begin
            span      = (OFF_W+1)'(4);
            lane_mask = BYTES'(4'b1111);
            align_ok  = (offset[1:0] == 2'b00);
         end
         default: ;
      endcase
   end

   assign fit_ok   = ({1'b0, offset} + span) <= (OFF_W+1)'(BYTES);
   assign range_ok = word_addr < WIDTH'(MAX_ADDR);
   assign legal    = (size != SZ_RSVD) && align_ok && fit_ok && range_ok;

   assign ram_we    = (any_grant && write && legal) ? BYTES'(lane_mask << offset) : '0;
   assign ram_wdata = any_grant ? (wdata << {offset, 3'b000}) : '0;
   assign ram_addr  = any_grant ? word_addr : addr_hold_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         addr_hold_q <= '0;
      else if (any_grant) addr_hold_q <= word_addr;
   end

   always_comb begin
      rsp_d        = '0;
      rsp_d.valid  = any_grant;
      rsp_d.owner  = sel;
      rsp_d.offset = OFF_MAX_W'(offset);
      rsp_d.size   = size;
      rsp_d.write  = write;
      rsp_d.err    = ~legal;
   end

   // Clearing the stage on reset drops any response still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rsp_q <= '0;
      else        rsp_q <= rsp_d;
   end

   assign rd_shift = ram_rdata >> {rsp_q.offset, 3'b000};
   assign rsp_err  = rsp_q.valid & rsp_q.err;

   always_comb begin
      rsp_valid = '0;
      rsp_rdata = '0;
      if (rsp_q.valid) rsp_valid[rsp_q.owner] = 1'b1;
      if (rsp_q.valid && !rsp_q.write && !rsp_q.err) begin
         unique case (rsp_q.size)
            SZ_BYTE: rsp_rdata = WIDTH'(rd_shift[7:0]);
            SZ_HALF: rsp_rdata = WIDTH'(rd_shift[15:0]);
            SZ_WORD: rsp_rdata = WIDTH'(rd_shift[31:0]);
            default: rsp_rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural port-A RAM.
// Expected grants follow ARB_ROUND_ROBIN_EN when it is defined.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
   import ram_arb_pkg::*;

   localparam int          BYTES    = 4;
   localparam int          WIDTH    = 32;
   localparam logic [31:0] MAX_ADDR = 32'h1000;

   logic                          clk = 1'b0;
   logic                          rst_n;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_addr;
   logic [NUM_REQ-1:0]            req_write;
   logic [NUM_REQ-1:0][1:0]       req_size;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [WIDTH-1:0]              rsp_rdata;
   logic                          rsp_err;
   logic [WIDTH-1:0]              ram_addr;
   logic [BYTES-1:0]              ram_we;
   logic [WIDTH-1:0]              ram_wdata;
   logic [WIDTH-1:0]              ram_rdata;

   ram_port_arbiter #(.BYTES(BYTES), .WIDTH(WIDTH), .MAX_ADDR(MAX_ADDR)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Port A of the block RAM: byte-enabled write, registered read.
   logic [WIDTH-1:0] mem [MAX_ADDR];
   always @(posedge clk) begin
      if (ram_addr < MAX_ADDR) begin
         for (int b = 0; b < BYTES; b++)
            if (ram_we[b]) mem[ram_addr[11:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
         ram_rdata <= mem[ram_addr[11:0]];
      end else begin
         ram_rdata <= '0;
      end
   end

   typedef struct {
      logic             owner;
      logic [WIDTH-1:0] rdata;
      logic             err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every response the DUT presents is matched against the queue.
   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid != '0) begin
         check("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_rsp: rsp_valid=%b with nothing outstanding", rsp_valid);
         end else begin
            e = exp_q.pop_front();
            check("rsp_owner", 64'(rsp_valid[1]), 64'(e.owner));
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check("rsp_err",   64'(rsp_err),   64'(e.err));
         end
      end
   end

   // Issues one request, checks the RAM-side outputs in its grant cycle and
   // queues the expected response. Called just after a rising edge.
   task automatic do_req(input int r, input logic [31:0] addr, input logic wr,
                         input logic [1:0] sz, input logic [31:0] wd,
                         input logic [3:0] exp_we, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input string tag);
      int waited = 0;
      req_addr[r]  = addr;
      req_write[r] = wr;
      req_size[r]  = sz;
      req_wdata[r] = wd;
      req_valid[r] = 1'b1;
      @(negedge clk);
      while (!req_ready[r] && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready[r]) begin
         n_checks++;
         $display("FAIL %s_grant: req_ready[%0d] still 0 after 20 cycles", tag, r);
      end else begin
         check({tag, "_we"},   64'(ram_we),   64'(exp_we));
         check({tag, "_addr"}, 64'(ram_addr), 64'(addr >> 2));
         if (exp_we != 4'b0000) check({tag, "_wdata"}, 64'(ram_wdata), 64'(exp_wdata));
         exp_q.push_back('{owner: r[0], rdata: exp_rdata, err: exp_err});
      end
      @(posedge clk);
      #1;
      req_valid[r] = 1'b0;
   endtask

   // Contest table: per-cycle valids and the grant expected for each.
   logic [1:0] arb_valid [5] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10};
`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0] arb_grant [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
`else
   logic [1:0] arb_grant [5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 2'b11;
      req_addr  = '{32'h20, 32'h10};
      req_write = '0;
      req_size  = '{2'd2, 2'd2};
      req_wdata = '0;

      repeat (2) @(negedge clk);
      check("rst_ready",     64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_err",   64'(rsp_err),   64'd0);
      check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      check("rst_ram_we",    64'(ram_we),    64'd0);
      check("rst_ram_addr",  64'(ram_addr),  64'd0);
      req_valid = '0;
      rst_n     = 1'b1;
      @(posedge clk);
      #1;

      //     r  addr        wr    sz    wdata         we       ram_wdata     rdata         err
      do_req(0, 32'h10,     1'b1, 2'd2, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0, "st_w10");
      do_req(0, 32'h11,     1'b0, 2'd0, 32'h0,        4'b0000, 32'h0,        32'h000000BE, 1'b0, "ld_b11");
      do_req(0, 32'h20,     1'b1, 2'd2, 32'h11223344, 4'b1111, 32'h11223344, 32'h0,        1'b0, "st_w20");
      do_req(0, 32'h22,     1'b1, 2'd1, 32'h5555ABCD, 4'b1100, 32'hABCD0000, 32'h0,        1'b0, "st_h22");
      do_req(0, 32'h20,     1'b0, 2'd2, 32'h0,        4'b0000, 32'h0,        32'hABCD3344, 1'b0, "ld_w20");
      do_req(1, 32'h22,     1'b0, 2'd1, 32'h0,        4'b0000, 32'h0,        32'h0000ABCD, 1'b0, "ld_h22");
      do_req(1, 32'h23,     1'b0, 2'd0, 32'h0,        4'b0000, 32'h0,        32'h000000AB, 1'b0, "ld_b23");
      do_req(1, 32'h13,     1'b1, 2'd0, 32'h00000077, 4'b1000, 32'h77000000, 32'h0,        1'b0, "st_b13");
      do_req(0, 32'h10,     1'b0, 2'd2, 32'h0,        4'b0000, 32'h0,        32'h77ADBEEF, 1'b0, "ld_w10");
      do_req(0, 32'h3,      1'b0, 2'd2, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, "ld_w3_mis");
      do_req(1, 32'h11,     1'b1, 2'd2, 32'hFFFFFFFF, 4'b0000, 32'h0,        32'h0,        1'b1, "st_w11_mis");
      do_req(0, 32'h11,     1'b1, 2'd1, 32'h00009999, 4'b0000, 32'h0,        32'h0,        1'b1, "st_h11_mis");
      do_req(0, 32'h40,     1'b0, 2'd3, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, "ld_rsvd");
      do_req(0, 32'h4000,   1'b0, 2'd2, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, "ld_oor");
      do_req(1, 32'h4000,   1'b1, 2'd0, 32'h000000EE, 4'b0000, 32'h0,        32'h0,        1'b1, "st_oor");
      do_req(0, 32'h10,     1'b0, 2'd2, 32'h0,        4'b0000, 32'h0,        32'h77ADBEEF, 1'b0, "ld_w10_keep");
      do_req(0, 32'h3FFC,   1'b1, 2'd2, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0, "st_top");
      do_req(1, 32'h3FFE,   1'b0, 2'd1, 32'h0,        4'b0000, 32'h0,        32'h0000CAFE, 1'b0, "ld_top");

      // Both requesters contend; requester 1 keeps waiting while 0 hogs.
      req_addr  = '{32'h20, 32'h10};
      req_write = '0;
      req_size  = '{2'd2, 2'd2};
      for (int c = 0; c < 5; c++) begin
         req_valid = arb_valid[c];
         @(negedge clk);
         check($sformatf("arb_grant_c%0d", c), 64'(req_ready), 64'(arb_grant[c]));
         if (req_ready == 2'b01) exp_q.push_back('{owner: 1'b0, rdata: 32'h77ADBEEF, err: 1'b0});
         if (req_ready == 2'b10) exp_q.push_back('{owner: 1'b1, rdata: 32'hABCD3344, err: 1'b0});
         @(posedge clk);
         #1;
      end
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset right after a load grant: its response must never appear.
      req_valid = 2'b01;
      @(negedge clk);
      check("pre_rst_grant", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      req_valid = '0;
      rst_n     = 1'b0;
      @(negedge clk);
      check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("midrst_ram_addr",  64'(ram_addr),  64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("post_rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      check("post_rst_ram_we",    64'(ram_we),    64'd0);
      check("post_rst_ram_addr",  64'(ram_addr),  64'd0);
      @(posedge clk);
      #1;
      req_valid = 2'b11;
      @(negedge clk);
      check("post_rst_first_grant", 64'(req_ready), 64'd1);
      if (req_ready == 2'b01) exp_q.push_back('{owner: 1'b0, rdata: 32'h77ADBEEF, err: 1'b0});
      @(posedge clk);
      #1;
      req_valid = '0;

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
